gpio_pad_arbiter: RTL and testbench

GPIO_PAD_ARBITER -- requirements
Module: gpio_pad_arbiter

---
 rtl/gpio_pad_arbiter.sv | 135 +++++++++++++
 tb/tb_gpio_pad_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_arbiter.sv
// Two-requester GPIO pad-bus arbiter with hi-Z turnaround and a 2-flop pad readback synchronizer.
// Define GPIO_PAD_ARB_HOLD_LIMIT_EN to compile in the MAX_HOLD ownership limit.
module gpio_pad_arbiter #(
  parameter int unsigned TA_CYCLES = 1,
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [1:0]        req_i,
  input  logic [DATA_W-1:0] out0_i,
  input  logic [DATA_W-1:0] out1_i,
  input  logic [DATA_W-1:0] en0_i,
  input  logic [DATA_W-1:0] en1_i,
  input  logic [DATA_W-1:0] io_pad_i,
  output logic [DATA_W-1:0] io_out_o,
  output logic [DATA_W-1:0] io_en_o,
  output logic [1:0]        gnt_o,
  output logic [DATA_W-1:0] pad_rd_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

  localparam logic [3:0] TA_LOAD = 4'(TA_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  state_t            arb_next;
  logic              last_owner;
  logic [3:0]        ta_cnt;
  logic [DATA_W-1:0] pad_meta_p0;
  logic              own_idx;
  logic              own_req;
  logic              other_req;
  logic              hold_force;

  // Ties go to whichever requester did not own the bus last.
  function automatic state_t arbitrate(input logic [1:0] req, input logic last);
    case (req)
      2'b01:   return OWN0;
      2'b10:   return OWN1;
      2'b11:   return last ? OWN0 : OWN1;
      default: return IDLE;
    endcase
  endfunction

`ifdef GPIO_PAD_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= HOLD_MAX) ? HOLD_MAX : v + 8'd1;
  endfunction

  // hold_cnt counts owned cycles already completed, so the edge ending the
  // MAX_HOLD-th owned cycle is the one that forces release.
  assign hold_force = (hold_cnt >= HOLD_LAST) && other_req;
`else
  assign hold_force = 1'b0;
`endif

  always_comb begin
    own_idx   = (state == OWN1);
    own_req   = req_i[own_idx];
    other_req = req_i[~own_idx];
    arb_next  = arbitrate(req_i, last_owner);
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = arb_next;
      OWN0, OWN1: if (!own_req || hold_force) state_nxt = TURN;
      TURN:       if (ta_cnt == 4'd0) state_nxt = arb_next;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      ta_cnt      <= 4'd0;
      gnt_o       <= 2'b00;
      io_en_o     <= '0;
      io_out_o    <= '0;
      busy_o      <= 1'b0;
      pad_meta_p0 <= '0;
      pad_rd_o    <= '0;
`ifdef GPIO_PAD_ARB_HOLD_LIMIT_EN
      hold_cnt    <= 8'd0;
`endif
    end else begin
      // p0: first synchronizer flop; p1: pad_rd_o
      pad_meta_p0 <= io_pad_i;
      pad_rd_o    <= pad_meta_p0;

      state  <= state_nxt;
      busy_o <= (state_nxt != IDLE);

      case (state_nxt)
        OWN0: begin
          gnt_o    <= 2'b01;
          io_out_o <= out0_i;
          io_en_o  <= en0_i;
        end
        OWN1: begin
          gnt_o    <= 2'b10;
          io_out_o <= out1_i;
          io_en_o  <= en1_i;
        end
        default: begin
          gnt_o   <= 2'b00;
          io_en_o <= '0;
        end
      endcase

      if (state_nxt == TURN && state != TURN)
        ta_cnt <= TA_LOAD;
      else if (state == TURN && ta_cnt != 4'd0)
        ta_cnt <= ta_cnt - 4'd1;

      if ((state_nxt == OWN0 || state_nxt == OWN1) && state_nxt != state)
        last_owner <= (state_nxt == OWN1);

`ifdef GPIO_PAD_ARB_HOLD_LIMIT_EN
      if ((state_nxt == OWN0 || state_nxt == OWN1) && state_nxt != state)
        hold_cnt <= 8'd0;
      else if (state == OWN0 || state == OWN1)
        hold_cnt <= sat_inc(hold_cnt);
`endif
    end
  end

endmodule

// File: tb/tb_gpio_pad_arbiter.sv
// Directed bench for gpio_pad_arbiter: vector table plus turnaround, hold-limit,
// async-reset and synchronizer sequences. Instances with TA_CYCLES=1 and TA_CYCLES=3.
module tb_gpio_pad_arbiter;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_i;
  logic [31:0] out0_i, out1_i, en0_i, en1_i, io_pad_i;
  logic [31:0] io_out_o, io_en_o, pad_rd_o;
  logic [1:0]  gnt_o;
  logic        busy_o;
  logic [31:0] io_out3, io_en3, pad_rd3;
  logic [1:0]  gnt3;
  logic        busy3;

  int checks = 0;
  int errors = 0;

  gpio_pad_arbiter #(.TA_CYCLES(1), .MAX_HOLD(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_i(req_i),
    .out0_i(out0_i), .out1_i(out1_i), .en0_i(en0_i), .en1_i(en1_i),
    .io_pad_i(io_pad_i), .io_out_o(io_out_o), .io_en_o(io_en_o),
    .gnt_o(gnt_o), .pad_rd_o(pad_rd_o), .busy_o(busy_o)
  );

  gpio_pad_arbiter #(.TA_CYCLES(3), .MAX_HOLD(16)) dut3 (
    .PCLK(PCLK), .PRESET(PRESET), .req_i(req_i),
    .out0_i(out0_i), .out1_i(out1_i), .en0_i(en0_i), .en1_i(en1_i),
    .io_pad_i(io_pad_i), .io_out_o(io_out3), .io_en_o(io_en3),
    .gnt_o(gnt3), .pad_rd_o(pad_rd3), .busy_o(busy3)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] out0, out1, en0, en1;
    logic [1:0]  gnt;
    logic [31:0] en, out;
    logic        busy;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    req_i  = 2'b00;
    #3;
    PRESET = 1'b0;
  endtask

  // Enables may only be driven under a grant, and grants are never shared.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      chk("inv_dut", {31'd0, ((io_en_o != 0) && (gnt_o == 0)) || (gnt_o == 2'b11)}, 32'd0);
      chk("inv_dut3", {31'd0, ((io_en3 != 0) && (gnt3 == 0)) || (gnt3 == 2'b11)}, 32'd0);
    end
  end

  initial begin
    logic [1:0] eg;

    vecs[0]  = '{2'b01, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h0000FFFF, 2'b01, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b1};
    vecs[1]  = '{2'b01, 32'h12345678, 32'h5A5A5A5A, 32'h00FF00FF, 32'h0000FFFF, 2'b01, 32'h00FF00FF, 32'h12345678, 1'b1};
    vecs[2]  = '{2'b11, 32'hCAFEF00D, 32'h5A5A5A5A, 32'hFFFF0000, 32'h0000FFFF, 2'b01, 32'hFFFF0000, 32'hCAFEF00D, 1'b1};
    vecs[3]  = '{2'b10, 32'hCAFEF00D, 32'h5A5A5A5A, 32'hFFFF0000, 32'h0000FFFF, 2'b00, 32'h00000000, 32'hCAFEF00D, 1'b1};
    vecs[4]  = '{2'b10, 32'hCAFEF00D, 32'h5A5A5A5A, 32'hFFFF0000, 32'h0000FFFF, 2'b10, 32'h0000FFFF, 32'h5A5A5A5A, 1'b1};
    vecs[5]  = '{2'b11, 32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF0000, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1};
    vecs[6]  = '{2'b01, 32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF0000, 32'hFFFFFFFF, 2'b00, 32'h00000000, 32'hDEADBEEF, 1'b1};
    vecs[7]  = '{2'b11, 32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF0000, 32'hFFFFFFFF, 2'b01, 32'hFFFF0000, 32'hCAFEF00D, 1'b1};
    vecs[8]  = '{2'b00, 32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF0000, 32'hFFFFFFFF, 2'b00, 32'h00000000, 32'hCAFEF00D, 1'b1};
    vecs[9]  = '{2'b00, 32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF0000, 32'hFFFFFFFF, 2'b00, 32'h00000000, 32'hCAFEF00D, 1'b0};
    vecs[10] = '{2'b11, 32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF0000, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1};
    vecs[11] = '{2'b00, 32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF0000, 32'hFFFFFFFF, 2'b00, 32'h00000000, 32'hDEADBEEF, 1'b1};
    vecs[12] = '{2'b10, 32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF0000, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1};
    vecs[13] = '{2'b00, 32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF0000, 32'hFFFFFFFF, 2'b00, 32'h00000000, 32'hDEADBEEF, 1'b1};
    vecs[14] = '{2'b00, 32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFF0000, 32'hFFFFFFFF, 2'b00, 32'h00000000, 32'hDEADBEEF, 1'b0};

    PRESET   = 1'b1;
    req_i    = 2'b00;
    out0_i   = '0;
    out1_i   = '0;
    en0_i    = '0;
    en1_i    = '0;
    io_pad_i = '0;
    #12;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_en", io_en_o, 32'h0);
    chk("rst_out", io_out_o, 32'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_pad_rd", pad_rd_o, 32'h0);
    PRESET = 1'b0;

    for (int i = 0; i < 15; i++) begin
      req_i  = vecs[i].req;
      out0_i = vecs[i].out0;
      out1_i = vecs[i].out1;
      en0_i  = vecs[i].en0;
      en1_i  = vecs[i].en1;
      step();
      chk($sformatf("vec%0d_gnt", i), gnt_o, vecs[i].gnt);
      chk($sformatf("vec%0d_en", i), io_en_o, vecs[i].en);
      chk($sformatf("vec%0d_out", i), io_out_o, vecs[i].out);
      chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].busy);
    end

    // First tie after reset goes to requester 0, then one turnaround cycle.
    do_reset();
    out0_i = 32'h11111111; en0_i = 32'hFFFFFFFF;
    out1_i = 32'h22222222; en1_i = 32'h0000FFFF;
    req_i = 2'b11;
    step();
    chk("tie_gnt", gnt_o, 2'b01);
    req_i = 2'b10;
    step();
    chk("ta1_gnt", gnt_o, 2'b00);
    chk("ta1_en", io_en_o, 32'h0);
    step();
    chk("ta1_next_gnt", gnt_o, 2'b10);
    chk("ta1_next_en", io_en_o, 32'h0000FFFF);

    // Three-cycle turnaround on the TA_CYCLES=3 instance.
    do_reset();
    req_i = 2'b10;
    step();
    chk("ta3_own1", gnt3, 2'b10);
    req_i = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("ta3_turn%0d_en", k), io_en3, 32'h0);
      chk($sformatf("ta3_turn%0d_gnt", k), gnt3, 2'b00);
      chk($sformatf("ta3_turn%0d_busy", k), busy3, 1'b1);
      if (k == 2) chk("ta1_par_gnt", gnt_o, 2'b01);
    end
    step();
    chk("ta3_grant0", gnt3, 2'b01);
    chk("ta3_en0", io_en3, 32'hFFFFFFFF);
    chk("ta3_out0", io_out3, 32'h11111111);

    // Both requesting continuously.
    do_reset();
    req_i = 2'b11;
`ifdef GPIO_PAD_ARB_HOLD_LIMIT_EN
    for (int i = 1; i <= 35; i++) begin
      step();
      if (i <= 16)      eg = 2'b01;
      else if (i == 17) eg = 2'b00;
      else if (i <= 33) eg = 2'b10;
      else if (i == 34) eg = 2'b00;
      else              eg = 2'b01;
      chk($sformatf("hold_c%0d", i), gnt_o, eg);
    end
`else
    eg = 2'b01;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk($sformatf("hold_c%0d", i), gnt_o, eg);
    end
`endif

    // Asynchronous reset while owner 1 drives.
    do_reset();
    req_i = 2'b10;
    en1_i = 32'h0000FFFF;
    step();
    chk("arst_pre_en", io_en_o, 32'h0000FFFF);
    PRESET = 1'b1;
    #1;
    chk("arst_en", io_en_o, 32'h0);
    chk("arst_gnt", gnt_o, 2'b00);
    #4;
    PRESET = 1'b0;
    step();
    chk("arst_post_gnt", gnt_o, 2'b10);
    chk("arst_post_en", io_en_o, 32'h0000FFFF);

    // Pad readback latency across IDLE, OWN and TURN.
    do_reset();
    io_pad_i = 32'h12345678;
    req_i = 2'b01;
    step();
    chk("sync_e1", pad_rd_o, 32'h0);
    step();
    chk("sync_e2_own", pad_rd_o, 32'h12345678);
    chk("sync_e2_own3", pad_rd3, 32'h12345678);
    io_pad_i = 32'h87654321;
    req_i = 2'b00;
    step();
    chk("sync_turn_e1", pad_rd_o, 32'h12345678);
    step();
    chk("sync_idle_e2", pad_rd_o, 32'h87654321);
    io_pad_i = 32'h12345678;
    step();
    chk("sync_idle2_e1", pad_rd_o, 32'h87654321);
    step();
    chk("sync_idle2_e2", pad_rd_o, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
